// File: rtl/cdt_pkg.sv
// Purpose: shared definitions for the countdown timer (CDT) Wishbone peripheral:
//          register word offsets, CTRL/STATUS bit positions, response state type, byte-lane helper.
// Ports:   none (package).
package cdt_pkg;

    // Register word offsets (byte address bits [3:2])
    localparam logic [1:0] REG_COUNT  = 2'd0;
    localparam logic [1:0] REG_RELOAD = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IE          = 2;
    localparam int CTRL_PRESC_LSB   = 8;

    // STATUS bit positions
    localparam int STATUS_EXPIRED   = 0;

    // Bus response state: a single outstanding request, answered one cycle after accept
    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_ACK  = 2'd1,
        RSP_ERR  = 2'd2
    } rsp_e;

    // Byte lane (sel bit) that carries a given bit of a 32-bit word
    function automatic logic [1:0] byte_lane(input int bit_idx);
        return 2'(bit_idx / 8);
    endfunction

endpackage

// File: rtl/cdt_core.sv
// Purpose: prescaler + down-counter + sticky expiry flag of the countdown timer.
// Latency: count/expiry update on the clock after a tick; load/clear strobes act on the next edge.
// Backpressure: none; bus-side load and clear strobes are always taken.
// Ports:   clk_i/rst_i (async active-high), en_i/auto_reload_i/presc_i/reload_i (config),
//          count_ld_i/count_ld_dat_i (COUNT write), expired_clr_i (W1C), count_o/expired_o (state).
module cdt_core #(
    parameter int COUNT_WIDTH = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   auto_reload_i,
    input  logic [PRESC_WIDTH-1:0] presc_i,
    input  logic [COUNT_WIDTH-1:0] reload_i,
    input  logic                   count_ld_i,
    input  logic [COUNT_WIDTH-1:0] count_ld_dat_i,
    input  logic                   expired_clr_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   expired_o
);

    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   expired_q, expired_d;
    logic                   tick;
    logic                   expire_set;

    // >= rather than == so that lowering PRESC below the running prescaler value
    // produces a tick immediately instead of wrapping through the full range.
    assign tick = en_i && (presc_q >= presc_i);

    always_comb begin
        presc_d    = presc_q;
        count_d    = count_q;
        expire_set = 1'b0;

        // Prescaler: held at 0 while disabled, restarted by a COUNT write
        if (!en_i || count_ld_i || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESC_WIDTH'(1);
        end

        // Counter: a bus load wins over a tick in the same cycle
        if (count_ld_i) begin
            count_d = count_ld_dat_i;
        end else if (tick) begin
            if (count_q > COUNT_WIDTH'(1)) begin
                count_d = count_q - COUNT_WIDTH'(1);
            end else if (count_q == COUNT_WIDTH'(1)) begin
                expire_set = 1'b1;
                count_d    = auto_reload_i ? reload_i : '0;
            end
        end

        // Setting the flag wins over a simultaneous write-1-to-clear
        expired_d = expire_set | (expired_q & ~expired_clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q   <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = expired_q;

endmodule

// File: rtl/wb_cdt_slave.sv
// Purpose: Wishbone pipelined slave for the countdown timer: decode, handshake, sel-masked writes, read mux.
// Latency: ack/err one cycle after accept, read data registered in the ack cycle.
// Backpressure: stall is high while a response is pending, so one request every 2 cycles at most.
// Ports:   clk/i_reset (async active-high), i_wb_m2s_* (master request), o_wb_s2m_* (response,
//          err_addr = last errored address), o_expired (STATUS.EXPIRED), o_irq when CDT_IRQ_EN is defined.
// Build option: CDT_IRQ_EN adds CTRL.IE and the registered o_irq output.
module wb_cdt_slave
    import cdt_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0010,
    parameter int          COUNT_WIDTH = 32,
    parameter int          PRESC_WIDTH = 8
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_wb_m2s_cyc,
    input  logic        i_wb_m2s_stb,
    input  logic        i_wb_m2s_we,
    input  logic [31:0] i_wb_m2s_addr,
    input  logic [3:0]  i_wb_m2s_sel,
    input  logic [31:0] i_wb_m2s_data,
    output logic [31:0] o_wb_s2m_data,
    output logic        o_wb_s2m_ack,
    output logic        o_wb_s2m_stall,
    output logic        o_wb_s2m_err,
    output logic [31:0] o_wb_s2m_err_addr,
    output logic        o_expired
`ifdef CDT_IRQ_EN
    ,
    output logic        o_irq
`endif
);

    logic                   accept;
    logic                   addr_hit;
    logic [1:0]             word_sel;
    logic                   wr_acc;
    logic                   rd_acc;

    rsp_e                   rsp_q;
    logic [31:0]            rdat_q, rdat_d;
    logic [31:0]            err_addr_q;

    logic [COUNT_WIDTH-1:0] reload_q, reload_d;
    logic                   ctrl_en_q, ctrl_en_d;
    logic                   ctrl_auto_q, ctrl_auto_d;
    logic [PRESC_WIDTH-1:0] ctrl_presc_q, ctrl_presc_d;
    logic                   ctrl_ie_q;

    logic [COUNT_WIDTH-1:0] count;
    logic                   expired;
    logic                   count_ld;
    logic [COUNT_WIDTH-1:0] count_ld_dat;
    logic                   expired_clr;

    logic [31:0]            count_rd, reload_rd, ctrl_rd, status_rd;

    // ---------------------------------------------------------------- decode
    assign o_wb_s2m_stall = (rsp_q != RSP_IDLE);
    assign accept   = i_wb_m2s_cyc & i_wb_m2s_stb & ~o_wb_s2m_stall;
    assign addr_hit = (i_wb_m2s_addr[31:4] == BASE_ADDR[31:4]) && (i_wb_m2s_addr[1:0] == 2'b00);
    assign word_sel = i_wb_m2s_addr[3:2];
    assign wr_acc   = accept & addr_hit & i_wb_m2s_we;
    assign rd_acc   = accept & addr_hit & ~i_wb_m2s_we;

    // ---------------------------------------------------------------- register views (zero-extended)
    always_comb begin
        count_rd  = 32'(count);
        reload_rd = 32'(reload_q);
        ctrl_rd   = '0;
        ctrl_rd[CTRL_EN]                         = ctrl_en_q;
        ctrl_rd[CTRL_AUTO_RELOAD]                = ctrl_auto_q;
        ctrl_rd[CTRL_IE]                         = ctrl_ie_q;
        ctrl_rd[CTRL_PRESC_LSB +: PRESC_WIDTH]   = ctrl_presc_q;
        status_rd = '0;
        status_rd[STATUS_EXPIRED]                = expired;
    end

    // ---------------------------------------------------------------- read mux (sampled at accept)
    always_comb begin
        rdat_d = '0;
        if (rd_acc) begin
            case (word_sel)
                REG_COUNT:  rdat_d = count_rd;
                REG_RELOAD: rdat_d = reload_rd;
                REG_CTRL:   rdat_d = ctrl_rd;
                REG_STATUS: rdat_d = status_rd;
                default:    rdat_d = '0;
            endcase
        end
    end

    // ---------------------------------------------------------------- sel-masked writes
    always_comb begin
        reload_d     = reload_q;
        ctrl_en_d    = ctrl_en_q;
        ctrl_auto_d  = ctrl_auto_q;
        ctrl_presc_d = ctrl_presc_q;
        count_ld     = 1'b0;
        expired_clr  = 1'b0;

        // COUNT merge is built against the live count so unselected bytes keep their value
        for (int i = 0; i < COUNT_WIDTH; i++) begin
            count_ld_dat[i] = i_wb_m2s_sel[byte_lane(i)] ? i_wb_m2s_data[i] : count[i];
        end

        if (wr_acc) begin
            case (word_sel)
                REG_COUNT: begin
                    count_ld = 1'b1;
                end
                REG_RELOAD: begin
                    for (int i = 0; i < COUNT_WIDTH; i++) begin
                        if (i_wb_m2s_sel[byte_lane(i)]) begin
                            reload_d[i] = i_wb_m2s_data[i];
                        end
                    end
                end
                REG_CTRL: begin
                    if (i_wb_m2s_sel[byte_lane(CTRL_EN)]) begin
                        ctrl_en_d = i_wb_m2s_data[CTRL_EN];
                    end
                    if (i_wb_m2s_sel[byte_lane(CTRL_AUTO_RELOAD)]) begin
                        ctrl_auto_d = i_wb_m2s_data[CTRL_AUTO_RELOAD];
                    end
                    for (int i = 0; i < PRESC_WIDTH; i++) begin
                        if (i_wb_m2s_sel[byte_lane(CTRL_PRESC_LSB + i)]) begin
                            ctrl_presc_d[i] = i_wb_m2s_data[CTRL_PRESC_LSB + i];
                        end
                    end
                end
                REG_STATUS: begin
                    expired_clr = i_wb_m2s_sel[byte_lane(STATUS_EXPIRED)] & i_wb_m2s_data[STATUS_EXPIRED];
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            reload_q     <= '0;
            ctrl_en_q    <= 1'b0;
            ctrl_auto_q  <= 1'b0;
            ctrl_presc_q <= '0;
            rdat_q       <= '0;
        end else begin
            reload_q     <= reload_d;
            ctrl_en_q    <= ctrl_en_d;
            ctrl_auto_q  <= ctrl_auto_d;
            ctrl_presc_q <= ctrl_presc_d;
            rdat_q       <= rdat_d;
        end
    end

    // ---------------------------------------------------------------- response FSM
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            rsp_q      <= RSP_IDLE;
            err_addr_q <= '0;
        end else begin
            if (accept) begin
                rsp_q <= addr_hit ? RSP_ACK : RSP_ERR;
                if (!addr_hit) begin
                    err_addr_q <= i_wb_m2s_addr;
                end
            end else begin
                rsp_q <= RSP_IDLE;
            end
        end
    end

    // A master that drops cyc in the response cycle has abandoned the request
    assign o_wb_s2m_ack      = (rsp_q == RSP_ACK) & i_wb_m2s_cyc;
    assign o_wb_s2m_err      = (rsp_q == RSP_ERR) & i_wb_m2s_cyc;
    assign o_wb_s2m_data     = rdat_q;
    assign o_wb_s2m_err_addr = err_addr_q;
    assign o_expired         = expired;

    // ---------------------------------------------------------------- optional interrupt
`ifdef CDT_IRQ_EN
    logic ctrl_ie_d;
    logic irq_q;

    always_comb begin
        ctrl_ie_d = ctrl_ie_q;
        if (wr_acc && (word_sel == REG_CTRL) && i_wb_m2s_sel[byte_lane(CTRL_IE)]) begin
            ctrl_ie_d = i_wb_m2s_data[CTRL_IE];
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            ctrl_ie_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_ie_q <= ctrl_ie_d;
            irq_q     <= expired & ctrl_ie_q;
        end
    end

    assign o_irq = irq_q;
`else
    assign ctrl_ie_q = 1'b0;
`endif

    // ---------------------------------------------------------------- timer core
    cdt_core #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_core (
        .clk_i          (clk),
        .rst_i          (i_reset),
        .en_i           (ctrl_en_q),
        .auto_reload_i  (ctrl_auto_q),
        .presc_i        (ctrl_presc_q),
        .reload_i       (reload_q),
        .count_ld_i     (count_ld),
        .count_ld_dat_i (count_ld_dat),
        .expired_clr_i  (expired_clr),
        .count_o        (count),
        .expired_o      (expired)
    );

endmodule
